// File: rtl/router_pkg.sv
// Shared types for the router output controller: header address encoding
// and the per-port watchdog state machine.
package router_pkg;

  typedef logic [1:0] addr_t;

  localparam addr_t ADDR_INVALID = 2'b11;
  localparam int    DEF_TIMEOUT  = 30;

  typedef enum logic [1:0] {
    WD_IDLE,
    WD_WAIT,
    WD_FLUSH
  } wdog_state_e;

endpackage

// File: rtl/router_out_wdog.sv
// Per-port starvation watchdog: a valid output left unread for TIMEOUT
// consecutive cycles earns a single-cycle soft_reset to flush its FIFO.
module router_out_wdog
  import router_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CNT_W   = $clog2(TIMEOUT)
) (
  input  logic clock,
  input  logic resetn,
  input  logic valid_out,
  input  logic read_enb,
  output logic soft_reset
);

  wdog_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= WD_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      WD_IDLE: begin
        cnt_d = '0;
        if (valid_out && !read_enb) begin
          state_d = WD_WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      WD_WAIT: begin
        // A read on the final count still rescues the port.
        if (read_enb || !valid_out) begin
          state_d = WD_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = WD_FLUSH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WD_FLUSH: begin
        state_d = WD_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = WD_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign soft_reset = (state_q == WD_FLUSH);

endmodule

// File: rtl/router_out_ctrl.sv
// Output-side controller of the 1x3 router: latches the header address,
// steers FIFO writes, drives valid_out and runs one watchdog per port.
module router_out_ctrl
  import router_pkg::*;
#(
  parameter int NPORT   = 3,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CNT_W   = $clog2(TIMEOUT)
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             detect_add,
  input  logic [1:0]       data_in,
  input  logic             write_enb_reg,
  input  logic [NPORT-1:0] full,
  input  logic [NPORT-1:0] empty,
  input  logic [NPORT-1:0] read_enb,
  output logic [NPORT-1:0] write_enb,
  output logic             fifo_full,
  output logic [NPORT-1:0] valid_out,
  output logic [NPORT-1:0] soft_reset
);

  addr_t addr_q, addr_d;

  always_comb begin
    addr_d = addr_q;
    if (detect_add) addr_d = data_in;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) addr_q <= '0;
    else         addr_q <= addr_d;
  end

  // Decode uses only the registered address, so data_in never reaches an output.
  always_comb begin
    write_enb = '0;
    fifo_full = 1'b0;
    if (addr_q != ADDR_INVALID) begin
      for (int i = 0; i < NPORT; i++) begin
        if (addr_q == addr_t'(i)) begin
          write_enb[i] = write_enb_reg;
          fifo_full    = full[i];
        end
      end
    end
  end

  assign valid_out = ~empty;

  for (genvar g = 0; g < NPORT; g++) begin : g_wdog
    router_out_wdog #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
    ) u_wdog (
      .clock      (clock),
      .resetn     (resetn),
      .valid_out  (valid_out[g]),
      .read_enb   (read_enb[g]),
      .soft_reset (soft_reset[g])
    );
  end

endmodule

// File: tb/tb_router_out_ctrl.sv
// Directed bench for router_out_ctrl: routing decode, invalid address,
// watchdog timeout/rescue/concurrency and mid-count reset.
module tb_router_out_ctrl;

  logic       clock;
  logic       resetn;
  logic       detect_add;
  logic [1:0] data_in;
  logic       write_enb_reg;
  logic [2:0] full, empty, read_enb;
  logic [2:0] write_enb, valid_out, soft_reset;
  logic       fifo_full;

  int checks = 0;
  int errors = 0;

  router_out_ctrl #(.NPORT(3), .TIMEOUT(30)) dut (
    .clock         (clock),
    .resetn        (resetn),
    .detect_add    (detect_add),
    .data_in       (data_in),
    .write_enb_reg (write_enb_reg),
    .full          (full),
    .empty         (empty),
    .read_enb      (read_enb),
    .write_enb     (write_enb),
    .fifo_full     (fifo_full),
    .valid_out     (valid_out),
    .soft_reset    (soft_reset)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Hold the current inputs for n edges; soft_reset must be zero until the
  // last edge, where it must equal pulse.
  task automatic run_expect(input string tag, input int n, input logic [2:0] pulse);
    for (int k = 1; k <= n; k++) begin
      tick();
      chk(tag, {5'd0, soft_reset}, {5'd0, (k == n) ? pulse : 3'b000});
    end
  endtask

  initial begin
    resetn = 1'b0; detect_add = 1'b0; data_in = 2'b00; write_enb_reg = 1'b0;
    full = 3'b001; empty = 3'b010; read_enb = 3'b000;
    #12;
    chk("rst_write_enb",  {5'd0, write_enb},  8'h00);
    chk("rst_fifo_full",  {7'd0, fifo_full},  8'h01);
    chk("rst_soft_reset", {5'd0, soft_reset}, 8'h00);
    chk("rst_valid_out",  {5'd0, valid_out},  8'h05);
    write_enb_reg = 1'b1; #1;
    chk("rst_addr0_we",   {5'd0, write_enb},  8'h01);
    write_enb_reg = 1'b0; full = 3'b000; empty = 3'b111;
    @(negedge clock); resetn = 1'b1;

    // 1 routing to port 1
    tick();
    detect_add = 1'b1; data_in = 2'b01;
    tick();
    detect_add = 1'b0; data_in = 2'b10; write_enb_reg = 1'b1; full = 3'b010; #1;
    chk("route_we_p1",   {5'd0, write_enb}, 8'h02);
    chk("route_full_p1", {7'd0, fifo_full}, 8'h01);
    tick();
    chk("addr_held",     {5'd0, write_enb}, 8'h02);
    // header and write together: old address this cycle, new one after the edge
    detect_add = 1'b1; #1;
    chk("same_cyc_old",  {5'd0, write_enb}, 8'h02);
    tick();
    detect_add = 1'b0;
    chk("route_we_p2",   {5'd0, write_enb}, 8'h04);
    chk("route_full_p2", {7'd0, fifo_full}, 8'h00);

    // 2 invalid address
    detect_add = 1'b1; data_in = 2'b11;
    tick();
    detect_add = 1'b0; full = 3'b111; #1;
    chk("inv_we",   {5'd0, write_enb}, 8'h00);
    chk("inv_full", {7'd0, fifo_full}, 8'h00);
    write_enb_reg = 1'b0; full = 3'b000;

    // 3 timeout on port 2, single-cycle pulse
    empty = 3'b011; read_enb = 3'b000;
    run_expect("to_p2", 30, 3'b100);
    tick();
    chk("to_p2_drop", {5'd0, soft_reset}, 8'h00);
    empty = 3'b111;
    tick();

    // 4 rescue on the 30th unread cycle, then a full fresh timeout
    empty = 3'b110;
    run_expect("rescue_pre", 29, 3'b000);
    read_enb = 3'b001;
    tick();
    chk("rescue_edge", {5'd0, soft_reset}, 8'h00);
    read_enb = 3'b000;
    run_expect("rescue_post", 30, 3'b001);
    empty = 3'b111;
    tick();
    chk("rescue_drop", {5'd0, soft_reset}, 8'h00);
    tick();

    // 5 ports 0 and 1 time out together, port 2 reading keeps quiet
    empty = 3'b000; read_enb = 3'b100;
    run_expect("conc", 30, 3'b011);
    empty = 3'b111; read_enb = 3'b000;
    tick();
    chk("conc_drop", {5'd0, soft_reset}, 8'h00);

    // 6 reset mid-count on port 1 discards the count and the address
    detect_add = 1'b1; data_in = 2'b10;
    tick();
    detect_add = 1'b0; empty = 3'b101;
    run_expect("mid_pre", 20, 3'b000);
    resetn = 1'b0; write_enb_reg = 1'b1; full = 3'b001; #1;
    chk("mid_rst_sr",   {5'd0, soft_reset}, 8'h00);
    chk("mid_rst_we",   {5'd0, write_enb},  8'h01);
    chk("mid_rst_full", {7'd0, fifo_full},  8'h01);
    write_enb_reg = 1'b0; full = 3'b000;
    @(negedge clock); resetn = 1'b1;
    run_expect("mid_post", 30, 3'b010);
    empty = 3'b111;
    tick();
    chk("mid_drop", {5'd0, soft_reset}, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
